// File: rtl/data_mem_io.sv
// data_mem_io: word RAM plus I/O page (LED, synced switches, prescaled timer/irq); clk, reset, addr/wdata/we -> comb rdata, sw in, leds_out/irq out
module data_mem_io #(
  parameter int MEM_WORDS = 256,
  parameter int PRESC = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  input  logic [7:0]  sw,
  output logic [7:0]  leds_out,
  output logic        irq
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = PRESC > 1 ? $clog2(PRESC) : 1;
  logic [31:0] mem [MEM_WORDS];
  logic io_sel, tick, match, unused;
  logic [5:0] off;
  logic [AW-1:0] idx;
  logic [7:0] leds, sw_meta, sw_sync;
  logic [31:0] cnt, cmp, io_rd;
  logic [2:0] ctrl;
  logic flag;
  logic [PW-1:0] presc;
  logic wr_led, wr_cnt, wr_cmp, wr_ctrl, wr_stat;
  assign io_sel = addr[31:16] == 16'hFFFF;
  assign off = addr[7:2];
  assign idx = addr[AW+1:2];
  assign unused = ^{addr[1:0], addr[15:8]};
  assign wr_led = we && io_sel && off == 6'h0;
  assign wr_cnt = we && io_sel && off == 6'h2;
  assign wr_cmp = we && io_sel && off == 6'h3;
  assign wr_ctrl = we && io_sel && off == 6'h4;
  assign wr_stat = we && io_sel && off == 6'h5;
  assign tick = ctrl[0] && presc == PW'(PRESC - 1);
  assign match = cnt == cmp;
  assign leds_out = leds;
  assign irq = flag & ctrl[2];
  always_ff @(posedge clk)
    if (we && !io_sel && !reset) mem[idx] <= wdata;
  always_ff @(posedge clk) begin
    if (reset) begin
      leds <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
      cnt <= '0;
      cmp <= '0;
      ctrl <= '0;
      flag <= 1'b0;
      presc <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      presc <= (ctrl[0] && !tick) ? presc + 1'b1 : '0;
      if (wr_led) leds <= wdata[7:0];
      if (wr_cmp) cmp <= wdata;
      if (wr_ctrl) ctrl <= wdata[2:0];
      if (wr_cnt) cnt <= wdata;
      else if (tick) cnt <= (match && ctrl[1]) ? 32'd0 : cnt + 32'd1;
      if (tick && match) flag <= 1'b1;
      else if (wr_stat && wdata[0]) flag <= 1'b0;
    end
  end
  always_comb begin
    io_rd = off == 6'h0 ? {24'd0, leds} :
            off == 6'h1 ? {24'd0, sw_sync} :
            off == 6'h2 ? cnt :
            off == 6'h3 ? cmp :
            off == 6'h4 ? {29'd0, ctrl} :
            off == 6'h5 ? {31'd0, flag} : 32'd0;
    rdata = io_sel ? io_rd : mem[idx];
  end
endmodule

// File: tb/tb_data_mem_io.sv
// tb_data_mem_io: directed plus randomized checks of data_mem_io against a behavioural model
module tb_data_mem_io;
  localparam int MEM_WORDS = 256;
  localparam int PRESC = 4;
  localparam logic [31:0] LED = 32'hFFFF0000, SWA = 32'hFFFF0004, CNT = 32'hFFFF0008;
  localparam logic [31:0] CMP = 32'hFFFF000C, CTRL = 32'hFFFF0010, STATUS = 32'hFFFF0014;
  logic clk = 1'b0, reset = 1'b1, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [7:0] sw = '0;
  logic [31:0] rdata;
  logic [7:0] leds_out;
  logic irq;
  int checks = 0, failures = 0;
  data_mem_io #(.MEM_WORDS(MEM_WORDS), .PRESC(PRESC)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we),
    .rdata(rdata), .sw(sw), .leds_out(leds_out), .irq(irq)
  );
  always #5 clk = ~clk;
  logic [31:0] m_ram [int];
  logic [7:0] m_leds;
  logic [31:0] m_cnt, m_cmp;
  logic [2:0] m_ctrl;
  logic m_flag;
  int m_phase;
  logic [7:0] m_sw [$];
  bit m_known = 1'b0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic bit is_io(input logic [31:0] a);
    return a[31:16] == 16'hFFFF;
  endfunction
  function automatic int ram_idx(input logic [31:0] a);
    return int'(a[31:2] % MEM_WORDS);
  endfunction
  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!is_io(a)) return m_ram.exists(ram_idx(a)) ? m_ram[ram_idx(a)] : 'x;
    case (a[7:2])
      6'd0: return {24'd0, m_leds};
      6'd1: return {24'd0, m_sw[0]};
      6'd2: return m_cnt;
      6'd3: return m_cmp;
      6'd4: return {29'd0, m_ctrl};
      6'd5: return {31'd0, m_flag};
      default: return 32'd0;
    endcase
  endfunction
  task automatic m_step(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
    bit tk, mt;
    logic [31:0] cnt_n;
    logic flag_n;
    if (r) begin
      m_leds = '0; m_cnt = '0; m_cmp = '0; m_ctrl = '0; m_flag = 1'b0; m_phase = 0;
      m_sw = '{8'd0, 8'd0};
      m_known = 1'b1;
      return;
    end
    tk = m_ctrl[0] && m_phase == PRESC - 1;
    mt = m_cnt == m_cmp;
    cnt_n = tk ? ((mt && m_ctrl[1]) ? 32'd0 : m_cnt + 32'd1) : m_cnt;
    flag_n = m_flag | (tk & mt);
    m_phase = m_ctrl[0] ? (m_phase + 1) % PRESC : 0;
    m_sw.push_back(sw);
    void'(m_sw.pop_front());
    if (w) begin
      if (!is_io(a)) m_ram[ram_idx(a)] = d;
      else case (a[7:2])
        6'd0: m_leds = d[7:0];
        6'd2: cnt_n = d;
        6'd3: m_cmp = d;
        6'd4: m_ctrl = d[2:0];
        6'd5: if (d[0] && !(tk && mt)) flag_n = 1'b0;
        default: ;
      endcase
    end
    m_cnt = cnt_n;
    m_flag = flag_n;
  endtask
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
    logic [31:0] e;
    addr = a; wdata = d; we = w; reset = r;
    #1;
    if (m_known) begin
      e = m_read(a);
      if (!$isunknown(e)) chk("rdata", rdata, e);
      chk("leds", {24'd0, leds_out}, {24'd0, m_leds});
      chk("irq", {31'd0, irq}, {31'd0, m_flag & m_ctrl[2]});
    end
    @(posedge clk);
    m_step(a, d, w, r);
    @(negedge clk);
  endtask
  task automatic expect_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a; we = 1'b0; reset = 1'b0;
    #1;
    chk(tag, rdata, exp);
  endtask
  task automatic idle(input int n);
    repeat (n) step(CNT, 32'd0, 1'b0, 1'b0);
  endtask
  task automatic wait_tick();
    int guard = 0;
    while (!(m_ctrl[0] && m_phase == PRESC - 1) && guard < 20) begin
      idle(1);
      guard++;
    end
    chk("tick_wait", m_phase, PRESC - 1);
  endtask
  initial begin
    int k;
    logic [31:0] a, d;
    step(32'd0, 32'd0, 1'b0, 1'b1);
    expect_rd("rst_cnt", CNT, 32'd0);
    expect_rd("rst_ctrl", CTRL, 32'd0);
    expect_rd("rst_status", STATUS, 32'd0);
    step(32'h10, 32'hDEADBEEF, 1'b1, 1'b0);
    expect_rd("ram_10", 32'h10, 32'hDEADBEEF);
    expect_rd("ram_13", 32'h13, 32'hDEADBEEF);
    step(32'h400, 32'h12345678, 1'b1, 1'b0);
    expect_rd("ram_wrap", 32'h0, 32'h12345678);
    step(LED, 32'h1A5, 1'b1, 1'b0);
    chk("leds_val", {24'd0, leds_out}, 32'hA5);
    expect_rd("led_rd", LED, 32'hA5);
    sw = 8'h3C;
    step(SWA, 32'd0, 1'b0, 1'b0);
    expect_rd("sw_1edge", SWA, 32'h0);
    idle(1);
    expect_rd("sw_2edge", SWA, 32'h3C);
    step(CMP, 32'd3, 1'b1, 1'b0);
    step(CTRL, 32'd7, 1'b1, 1'b0);
    idle(15);
    expect_rd("cnt_pre", CNT, 32'd3);
    expect_rd("flag_pre", STATUS, 32'd0);
    idle(1);
    expect_rd("cnt_clr", CNT, 32'd0);
    expect_rd("flag_set", STATUS, 32'd1);
    chk("irq_set", {31'd0, irq}, 32'd1);
    step(STATUS, 32'd1, 1'b1, 1'b0);
    chk("irq_clr", {31'd0, irq}, 32'd0);
    wait_tick();
    step(CNT, 32'd100, 1'b1, 1'b0);
    expect_rd("cnt_wr_tick", CNT, 32'd100);
    step(CMP, 32'd100, 1'b1, 1'b0);
    step(STATUS, 32'd1, 1'b1, 1'b0);
    wait_tick();
    step(STATUS, 32'd1, 1'b1, 1'b0);
    expect_rd("flag_keep", STATUS, 32'd1);
    expect_rd("unmapped", 32'hFFFF0020, 32'd0);
    step(CNT, 32'd2, 1'b1, 1'b0);
    step(LED, 32'h55, 1'b1, 1'b0);
    step(32'd0, 32'd0, 1'b0, 1'b1);
    expect_rd("rst_cnt2", CNT, 32'd0);
    expect_rd("rst_flag2", STATUS, 32'd0);
    expect_rd("ram_keep", 32'h10, 32'hDEADBEEF);
    chk("rst_leds", {24'd0, leds_out}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    repeat (2000) begin
      k = $urandom_range(0, 9);
      if (k < 6) a = {16'hFFFF, 8'($urandom), 3'd0, 3'($urandom_range(0, 7)), 2'($urandom)};
      else a = {16'($urandom_range(0, 65534)), 8'd0, 6'($urandom_range(0, 15)), 2'($urandom)};
      d = $urandom;
      if (is_io(a) && (a[7:2] == 6'd2 || a[7:2] == 6'd3)) d = $urandom_range(0, 8);
      if ($urandom_range(0, 19) == 0) sw = 8'($urandom);
      step(a, d, 1'($urandom_range(0, 1)), $urandom_range(0, 99) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
